// File: rtl/logic_unit_pipe.sv
// Bitwise logic functional unit for a Tomasulo-style core: one result stage (S1)
// feeding an in-order result buffer that is drained onto the common data bus.
module logic_unit_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [TAG_W-1:0] TAG,
  output logic             CDB_REQ,
  input  logic             CDB_GRANT,
  output logic [WIDTH-1:0] OUT,
  output logic [TAG_W-1:0] OUT_TAG,
  output logic             ZERO,
  output logic             BUSY
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_data;
  logic [TAG_W-1:0] r_s1_tag;

  logic [WIDTH-1:0] r_buf_data [DEPTH];
  logic [TAG_W-1:0] r_buf_tag  [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic [WIDTH-1:0] w_result;
  logic [CNT_W:0]   w_occupancy;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_head_data;
  logic [TAG_W-1:0] w_head_tag;

  always_comb begin
    w_result = A;
    case (OP)
      3'b000:  w_result = ~A;
      3'b001:  w_result = A & B;
      3'b010:  w_result = A | B;
      3'b011:  w_result = A ^ B;
      3'b100:  w_result = ~(A & B);
      3'b101:  w_result = ~(A | B);
      3'b110:  w_result = ~(A ^ B);
      default: w_result = A;
    endcase
  end

  // S1 is counted as occupied so an accepted issue always has a buffer slot waiting.
  assign w_occupancy = {1'b0, r_count} + {{CNT_W{1'b0}}, r_s1_valid};
  assign IN_READY    = w_occupancy < DEPTH_C;

  assign CDB_REQ = (r_count != '0);
  assign w_issue = IN_VALID & IN_READY & ~FLUSH;
  assign w_push  = r_s1_valid & ~FLUSH;
  assign w_pop   = CDB_REQ & CDB_GRANT & ~FLUSH;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_tag   <= '0;
    end else begin
      r_s1_valid <= w_issue;
      if (w_issue) begin
        r_s1_data <= w_result;
        r_s1_tag  <= TAG;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= (r_tail == LAST_PTR) ? '0 : r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= (r_head == LAST_PTR) ? '0 : r_head + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage carries no reset; only the control state decides what is live.
  always_ff @(posedge CLK) begin
    if (!RST && w_push) begin
      r_buf_data[r_tail] <= r_s1_data;
      r_buf_tag[r_tail]  <= r_s1_tag;
    end
  end

  assign w_head_data = r_buf_data[r_head];
  assign w_head_tag  = r_buf_tag[r_head];

  assign OUT     = CDB_REQ ? w_head_data : '0;
  assign OUT_TAG = CDB_REQ ? w_head_tag : '0;
  assign ZERO    = CDB_REQ & (w_head_data == '0);
  assign BUSY    = r_s1_valid | CDB_REQ;

endmodule
